// File: rtl/wbl_keygen_if.sv
// Request/response bundle for the WBL key generator: capture request in, 16 lane row words out.
interface wbl_keygen_if;
  logic         en;
  logic [127:0] Kin;
  logic [5:0]   addr;
  logic [63:0]  WBL1,  WBL2,  WBL3,  WBL4;
  logic [63:0]  WBL5,  WBL6,  WBL7,  WBL8;
  logic [63:0]  WBL9,  WBL10, WBL11, WBL12;
  logic [63:0]  WBL13, WBL14, WBL15, WBL16;
  logic         wbl_valid;

  modport master (
    output en, Kin, addr,
    input  WBL1, WBL2, WBL3, WBL4, WBL5, WBL6, WBL7, WBL8,
    input  WBL9, WBL10, WBL11, WBL12, WBL13, WBL14, WBL15, WBL16,
    input  wbl_valid
  );

  modport slave (
    input  en, Kin, addr,
    output WBL1, WBL2, WBL3, WBL4, WBL5, WBL6, WBL7, WBL8,
    output WBL9, WBL10, WBL11, WBL12, WBL13, WBL14, WBL15, WBL16,
    output wbl_valid
  );
endinterface

// File: rtl/wbl_keygen.sv
// Key-dependent write-bit-line generator: per lane, four {S(x^k), xtime(S(x^k))} entries
// for x = {addr, n}, computed combinationally and captured into registered row words.
module wbl_keygen (
  input logic         clk,
  input logic         rst,
  wbl_keygen_if.slave bus
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 through a fixed addition chain; a=0 naturally yields 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [15:0] entry(input logic [7:0] x);
    logic [7:0] s;
    s = sbox(x);
    return {s, xtime(s)};
  endfunction

  logic [15:0][63:0] row_s;
  logic [15:0][63:0] wbl_r;
  logic              valid_r;

  // Row words for all 16 lanes from the live key and address.
  always_comb begin
    row_s = {16{64'h0}};
    for (int j = 0; j < 16; j++) begin
      for (int n = 0; n < 4; n++) begin
        row_s[j][63-16*n -: 16] = entry({bus.addr, n[1:0]} ^ bus.Kin[127-8*j -: 8]);
      end
    end
  end

  // Output registers: reset clears, enable captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbl_r   <= {16{64'h0}};
      valid_r <= 1'b0;
    end else if (bus.en) begin
      wbl_r   <= row_s;
      valid_r <= 1'b1;
    end else begin
      wbl_r   <= wbl_r;
      valid_r <= valid_r;
    end
  end

  assign bus.WBL1      = wbl_r[0];
  assign bus.WBL2      = wbl_r[1];
  assign bus.WBL3      = wbl_r[2];
  assign bus.WBL4      = wbl_r[3];
  assign bus.WBL5      = wbl_r[4];
  assign bus.WBL6      = wbl_r[5];
  assign bus.WBL7      = wbl_r[6];
  assign bus.WBL8      = wbl_r[7];
  assign bus.WBL9      = wbl_r[8];
  assign bus.WBL10     = wbl_r[9];
  assign bus.WBL11     = wbl_r[10];
  assign bus.WBL12     = wbl_r[11];
  assign bus.WBL13     = wbl_r[12];
  assign bus.WBL14     = wbl_r[13];
  assign bus.WBL15     = wbl_r[14];
  assign bus.WBL16     = wbl_r[15];
  assign bus.wbl_valid = valid_r;

endmodule

// File: tb/tb_wbl_keygen.sv
// Self-checking bench for wbl_keygen: S-box table built by brute-force inversion,
// cycle model of capture/hold/reset, directed vectors, sweeps and random traffic.
module tb_wbl_keygen;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  wbl_keygen_if bus ();

  wbl_keygen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wire [63:0] obs [16];
  assign obs[0]  = bus.WBL1;   assign obs[1]  = bus.WBL2;
  assign obs[2]  = bus.WBL3;   assign obs[3]  = bus.WBL4;
  assign obs[4]  = bus.WBL5;   assign obs[5]  = bus.WBL6;
  assign obs[6]  = bus.WBL7;   assign obs[7]  = bus.WBL8;
  assign obs[8]  = bus.WBL9;   assign obs[9]  = bus.WBL10;
  assign obs[10] = bus.WBL11;  assign obs[11] = bus.WBL12;
  assign obs[12] = bus.WBL13;  assign obs[13] = bus.WBL14;
  assign obs[14] = bus.WBL15;  assign obs[15] = bus.WBL16;

  int          sbox_tbl [256];
  logic [63:0] m_row [16];
  logic        m_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced by the AES polynomial 0x11B.
  function automatic int pmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 1) == 1) p = p ^ ('h11B << (i - 8));
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s = 0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (pmul(x, y) == 1) inv = y;
      for (int i = 0; i < 8; i++) begin
        int b = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                 (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (b << i);
      end
      sbox_tbl[x] = s;
    end
  endtask

  function automatic logic [63:0] exp_row(input logic [127:0] key, input int a, input int lane);
    logic [63:0] r = 64'h0;
    int kb = int'((key >> (120 - 8 * lane)) & 128'hFF);
    for (int n = 0; n < 4; n++) begin
      int s = sbox_tbl[(a * 4 + n) ^ kb];
      int t = s * 2;
      if (t >= 256) t = t ^ 'h11B;
      r = r | (64'((s << 8) | t) << (48 - 16 * n));
    end
    return r;
  endfunction

  // Apply current inputs to the model, clock the DUT, then compare every lane and valid.
  task automatic tick(input string tag);
    if (rst) begin
      for (int j = 0; j < 16; j++) m_row[j] = 64'h0;
      m_valid = 1'b0;
    end else if (bus.en) begin
      for (int j = 0; j < 16; j++) m_row[j] = exp_row(bus.Kin, int'(bus.addr), j);
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < 16; j++) chk($sformatf("%s.wbl%0d", tag, j + 1), obs[j], m_row[j]);
    chk($sformatf("%s.valid", tag), 64'(bus.wbl_valid), 64'(m_valid));
  endtask

  initial begin
    logic [127:0] rkey;
    build_sbox();
    chk("sbox00", 64'(sbox_tbl[0]), 64'h63);
    chk("sbox53", 64'(sbox_tbl['h53]), 64'hED);

    // Reset wins over enable.
    rst = 1'b1;
    bus.en = 1'b1;
    bus.Kin = {$urandom, $urandom, $urandom, $urandom};
    bus.addr = 6'($urandom);
    tick("reset");
    tick("reset2");

    rst = 1'b0;
    bus.Kin = 128'h0;
    bus.addr = 6'd0;
    tick("k0a0");
    chk("k0a0.const1", bus.WBL1, 64'h63C6_7CF8_77EE_7BF6);
    chk("k0a0.const16", bus.WBL16, 64'h63C6_7CF8_77EE_7BF6);

    bus.addr = 6'd63;
    tick("k0a63");
    chk("k0a63.const1", bus.WBL1, 64'hB07B_54A8_BB6D_162C);
    chk("k0a63.const9", bus.WBL9, 64'hB07B_54A8_BB6D_162C);

    bus.Kin = 128'h0100_0000_0000_0000_0000_0000_0000_0000;
    bus.addr = 6'd0;
    tick("k01");
    chk("k01.const1", bus.WBL1, 64'h7CF8_63C6_7BF6_77EE);
    chk("k01.const2", bus.WBL2, 64'h63C6_7CF8_77EE_7BF6);
    chk("k01.const16", bus.WBL16, 64'h63C6_7CF8_77EE_7BF6);

    // Hold: inputs move while en is low, outputs must not.
    bus.Kin = 128'h0;
    tick("hold_cap");
    bus.en = 1'b0;
    bus.addr = 6'd63;
    for (int i = 0; i < 3; i++) tick($sformatf("hold%0d", i));
    chk("hold.const1", bus.WBL1, 64'h63C6_7CF8_77EE_7BF6);
    bus.en = 1'b1;
    tick("hold_rel");
    chk("hold_rel.const1", bus.WBL1, 64'hB07B_54A8_BB6D_162C);

    // Back-to-back address sweeps, zero key then a random key.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      bus.Kin = (k == 0) ? 128'h0 : rkey;
      for (int a = 0; a < 64; a++) begin
        bus.addr = 6'(a);
        tick($sformatf("sweep%0d_a%0d", k, a));
      end
    end

    // Random traffic with occasional reset and sparse enables.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      bus.en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) bus.Kin = {$urandom, $urandom, $urandom, $urandom};
      bus.addr = 6'($urandom);
      tick($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
